// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, NOP word, base opcodes.
// FETCH_ALIGN_CHECK_EN adds the HALT state used by the misaligned-redirect trap.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
`ifdef FETCH_ALIGN_CHECK_EN
    , HALT
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and imem (slave).
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests, registers the word for decode.
// FETCH_ALIGN_CHECK_EN: misaligned redirect targets trap into HALT and raise sticky misalign.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] pc_target,
  output logic            misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign redirect_pc = pc_target;
  assign misalign    = misalign_q;
`else
  assign redirect_pc = pc_target & {{(XLEN-2){1'b1}}, 2'b00};
  assign misalign    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d = misalign_q;
    // HALT is terminal until reset; a late response simply falls on the floor.
    if (state_q == HALT) begin
      kill_d = 1'b0;
    end else if (PCSrc && (pc_target[1:0] != 2'b00)) begin
      state_d    = HALT;
      misalign_d = 1'b1;
      kill_d     = 1'b0;
    end else
`endif
    if (PCSrc) begin
      pc_d = redirect_pc;
      case (state_q)
        // A request accepted this same cycle is for the old PC: remember to drop its data.
        REQ: begin
          if (imem.imem_req_ready) begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem.imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = REQ;
            end else begin
              instr_d    = imem.imem_rdata;
              instr_pc_d = pc_q;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = REQ;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_req_valid = (state_q == REQ);
  assign imem.imem_addr      = pc_q;

  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected requests/instructions queued by stimulus, popped by monitors.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     word;
    int unsigned     lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7;
  logic            PCSrc = 1'b0;
  logic [XLEN-1:0] pc_target = '0;
  logic            misalign;

  fetch_unit_if #(.XLEN(XLEN)) imem_bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .PCSrc       (PCSrc),
    .pc_target   (pc_target),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] req_q[$];
  exp_t            ins_q[$];
  int              checks = 0;
  int              errors = 0;
  int unsigned     mem_lat = 0;
  logic            mem_ready = 1'b1;
  logic            sb_on = 1'b0;
  int unsigned     cyc;
  int unsigned     last_req_cyc = 0;
  int unsigned     first_req_cyc = 0;
  logic            seen_req = 1'b0;
  logic            prev_valid = 1'b0;
  logic            pend;
  int unsigned     cnt;
  logic [XLEN-1:0] paddr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address-dependent content so every fetched word (and its decode fields) is distinguishable.
  function automatic logic [31:0] word_of(input logic [XLEN-1:0] a);
    return {a[9:2], a[9:2], a[9:2], 1'b0, (a[2] ? OP_LOAD : OP_ITYPE)};
  endfunction

  assign imem_bus.imem_req_ready = mem_ready;

  // Memory model: response mem_lat cycles after the accept edge (0 = very next cycle).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_bus.imem_rsp_valid <= 1'b0;
      imem_bus.imem_rdata     <= '0;
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= '0;
    end else begin
      imem_bus.imem_rsp_valid <= 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_bus.imem_rsp_valid <= 1'b1;
          imem_bus.imem_rdata     <= word_of(paddr);
          pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
        if (mem_lat == 0) begin
          imem_bus.imem_rsp_valid <= 1'b1;
          imem_bus.imem_rdata     <= word_of(imem_bus.imem_addr);
        end else begin
          pend  <= 1'b1;
          paddr <= imem_bus.imem_addr;
          cnt   <= mem_lat - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && sb_on) begin
      if (imem_bus.imem_req_valid && mem_ready) begin
        last_req_cyc = cyc;
        if (!seen_req) begin
          first_req_cyc = cyc;
          seen_req      = 1'b1;
        end
        check("req_expected", 64'(req_q.size() != 0), 64'd1);
        if (req_q.size() != 0) check("req_addr", 64'(imem_bus.imem_addr), 64'(req_q.pop_front()));
      end
      if (instr_valid && !prev_valid) begin
        check("instr_expected", 64'(ins_q.size() != 0), 64'd1);
        if (ins_q.size() != 0) begin
          exp_t e;
          e = ins_q.pop_front();
          check("instr",     64'(instr),    64'(e.word));
          check("instr_pc",  64'(instr_pc), 64'(e.pc));
          check("op",        64'(op),       64'(e.word[6:0]));
          check("funct3",    64'(funct3),   64'(e.word[14:12]));
          check("funct7",    64'(funct7),   64'(e.word[30]));
          check("latency",   64'(cyc - last_req_cyc), 64'(e.lat));
        end
      end
    end
    prev_valid = instr_valid && rst_n;
  end

  task automatic push_fetch(input logic [XLEN-1:0] a, input int unsigned lat);
    exp_t e;
    e.pc   = a;
    e.word = word_of(a);
    e.lat  = lat;
    req_q.push_back(a);
    ins_q.push_back(e);
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    rst_n = 1'b0;
    PCSrc = 1'b0;
    pc_target = '0;
    instr_ready = 1'b0;
    mem_ready = 1'b1;
    mem_lat = 0;
    req_q.delete();
    ins_q.delete();
    seen_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr",       64'(instr),                   64'(NOP_INSTR));
    check("rst_instr_pc",    64'(instr_pc),                64'd0);
    check("rst_instr_valid", 64'(instr_valid),             64'd0);
    check("rst_req_valid",   64'(imem_bus.imem_req_valid), 64'd0);
    check("rst_misalign",    64'(misalign),                64'd0);
    rst_n = 1'b1;
    sb_on = 1'b1;
  endtask

  task automatic wait_ins_empty(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (ins_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drained"}, 64'(ins_q.size()), 64'd0);
  endtask

  task automatic wait_req_empty(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (req_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drained"}, 64'(req_q.size()), 64'd0);
  endtask

  task automatic redirect_in_hold(input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] eff,
                                  input int unsigned n_follow);
    do_reset();
    push_fetch('0, 2);
    wait_ins_empty("hold_fill", 20);
    #1;
    PCSrc = 1'b1;
    pc_target = tgt;
    instr_ready = 1'b1;
    for (int unsigned k = 0; k < n_follow; k++) push_fetch(eff + XLEN'(4 * k), 2);
    @(posedge clk);
    #1;
    PCSrc = 1'b0;
    wait_ins_empty("hold_redir", 40);
    sb_on = 1'b0;
    check("hold_redir_req_left", 64'(req_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Zero-wait stream with decode always ready.
    do_reset();
    instr_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) push_fetch(XLEN'(4 * k), 2);
    wait_ins_empty("stream", 40);
    sb_on = 1'b0;
    check("stream_req_left", 64'(req_q.size()), 64'd0);
    check("first_req_cycle", 64'(first_req_cyc), 64'd1);

    // Backpressure: decode stalls five cycles in HOLD.
    do_reset();
    push_fetch('0, 2);
    wait_ins_empty("bp_fill", 20);
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid",     64'(instr_valid),             64'd1);
      check("bp_instr",     64'(instr),                   64'(word_of('0)));
      check("bp_no_req",    64'(imem_bus.imem_req_valid), 64'd0);
    end
    push_fetch(32'h4, 2);
    instr_ready = 1'b1;
    wait_ins_empty("bp_release", 20);
    sb_on = 1'b0;

    // Redirect while WAIT with a slow memory; the stale word must never surface.
    do_reset();
    mem_lat = 2;
    instr_ready = 1'b1;
    req_q.push_back('0);
    wait_req_empty("wait_first_req", 20);
    #1;
    PCSrc = 1'b1;
    pc_target = 32'h100;
    push_fetch(32'h100, 4);
    @(posedge clk);
    #1;
    PCSrc = 1'b0;
    wait_ins_empty("wait_redir", 40);
    sb_on = 1'b0;
    check("wait_redir_req_left", 64'(req_q.size()), 64'd0);

    // Redirect in HOLD with instr_ready high the same cycle, then PC wrap at the top.
    redirect_in_hold(32'h200, 32'h200, 1);
    redirect_in_hold(32'hFFFF_FFFC, 32'hFFFF_FFFC, 2);

    // Misaligned redirect target.
`ifdef FETCH_ALIGN_CHECK_EN
    do_reset();
    push_fetch('0, 2);
    wait_ins_empty("mis_fill", 20);
    #1;
    PCSrc = 1'b1;
    pc_target = 32'h102;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    PCSrc = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mis_flag",   64'(misalign),                64'd1);
      check("mis_no_req", 64'(imem_bus.imem_req_valid), 64'd0);
      check("mis_valid",  64'(instr_valid),             64'd0);
    end
    sb_on = 1'b0;
`else
    redirect_in_hold(32'h302, 32'h300, 1);
    check("mis_tied_low", 64'(misalign), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the riscy_core. It owns the program counter and issues one-at-a-time requests to instruction memory over a valid/ready handshake. It registers each returned word and presents it to the decode stage as `instr`, `op`, `funct3` and `funct7`. It consumes `PCSrc` and the branch/jump target from the control path and redirects fetch, discarding any wrong-path fetch still in flight.

## Interface
- `XLEN`, 32, address/PC width.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  XLEN  fetch address (current PC).
- `imem_rsp_valid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` holds a valid instruction for decode.
- `instr_ready`  in  1  decode consumes `instr` this cycle.
- `instr`  out  32  registered instruction.
- `instr_pc`  out  XLEN  PC of `instr`.
- `op`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7`  out  1  `instr[30]`.
- `PCSrc`  in  1  redirect request.
- `pc_target`  in  XLEN  redirect address, sampled when `PCSrc`=1.
- `misalign`  out  1  misaligned redirect flag, sticky; see Configuration.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, plus HALT (macro only).
- Reset values:
  - state=IDLE, pc=`RESET_PC`, kill=0.
  - `instr`=32'h0000_0013 (NOP), `instr_pc`=0, `instr_valid`=0, `imem_req_valid`=0, `misalign`=0.
- IDLE: go to REQ unconditionally on the next edge.
- REQ:
  - `imem_req_valid`=1 and `imem_addr`=pc.
  - On `imem_req_ready`, go to WAIT.
- WAIT:
  - On `imem_rsp_valid` with kill=0: `instr`<=`imem_rdata`, `instr_pc`<=pc, go to HOLD.
  - On `imem_rsp_valid` with kill=1: discard the data, clear kill, go to REQ.
- HOLD:
  - `instr_valid`=1.
  - On `instr_ready`: pc<=pc+4, go to REQ.
- Redirect (`PCSrc`=1) has priority over all other events in every state; pc<=`pc_target`.
  - IDLE/REQ with no handshake that cycle: go to REQ.
  - REQ with handshake in the same cycle: go to WAIT with kill=1.
  - WAIT, no response that cycle: set kill=1 and stay in WAIT.
  - WAIT with response in the same cycle: discard the response, go to REQ.
  - HOLD, including when `instr_ready` is high the same cycle: drop `instr_valid`, no pc+4, go to REQ.
- At most one outstanding memory request, at all times.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 wraps to 0.
- `op`/`funct3`/`funct7` are combinational slices of the `instr` register.
- They hold their value while `instr_valid`=0.

## Timing
- First `imem_req_valid` is the 2nd rising edge after `rst_n` deasserts (IDLE, then REQ).
- With a zero-wait memory (ready=1, response one cycle after the request): request in cycle N, `instr_valid` in cycle N+2.
- Peak throughput with `instr_ready` tied high: one instruction per 3 cycles.
- A redirect sampled at edge E produces its request at `imem_addr`=`pc_target` in the cycle after E, except when a killed response is pending.
- Reset assertion mid-transaction immediately forces all reset values; an in-flight response is ignored.
- `imem_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `pc_target[1:0]`≠0 enters HALT and sets `misalign`=1.
  - `misalign` is sticky until reset.
  - HALT issues no further requests and discards any outstanding response.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `pc_target[1:0]` is ignored (forced to 00).
  - HALT state does not exist.
  - `misalign` is tied to 0.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_e` enum.
  - `NOP_INSTR` = 32'h0000_0013.
  - Opcode constants (`OP_LOAD` 0000011, `OP_STORE` 0100011, `OP_RTYPE` 0110011, `OP_ITYPE` 0010011, `OP_JAL` 1101111, `OP_BRANCH` 1100011), shared with `ctrl`.
- Single module; no sub-module. Field extraction is inline.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0013 at 0x0: `imem_addr` 0x0 → `instr_valid` 2 cycles after the request; `op`=0010011, `funct3`=000.
- Stream with `instr_ready`=1: requests at 0x0, 0x4, 0x8, 0xC in order; `instr_pc` matches each address.
- Backpressure: `instr_ready`=0 for 5 cycles in HOLD → `instr` and `instr_valid` stable and no new request; on release the next request is 0x4.
- Redirect in WAIT (`PCSrc`=1, `pc_target`=0x100) → stale response dropped, never `instr_valid`; next request at 0x100.
- Redirect in HOLD with `instr_ready`=1 the same cycle → next request at target, not pc+4.
- With `FETCH_ALIGN_CHECK_EN`, `pc_target`=0x102 → `misalign`=1, `imem_req_valid` stays 0 until reset.
